// File: rtl/accum_scheduler.sv
// Round-robin scheduler that time-shares one add/subtract accumulator between
// NUM_REQ requesters, sequencing the fixed job d0 + d1 - d2 - d3.
module accum_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [1:0]         opnd,
  output logic [2:0]         cmd,
  output logic               valid,
  output logic [SEL_W-1:0]   done_id,
  output logic [NUM_REQ-1:0] ack,
  output logic               abort,
  output logic               busy
);

  localparam int NSEL = 1 << SEL_W;

  localparam logic [2:0] CMD_HOLD    = 3'b000;
  localparam logic [2:0] CMD_CAPTURE = 3'b001;
  localparam logic [2:0] CMD_ADD     = 3'b010;
  localparam logic [2:0] CMD_SUB     = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAP  = 3'd1,
    S_ADD  = 3'd2,
    S_SUB1 = 3'd3,
    S_SUB2 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [SEL_W-1:0]     sel_r;
  logic [SEL_W-1:0]     done_id_r;
  logic [SEL_W-1:0]     ptr_r;

  logic [NSEL-1:0]      req_ext_s;
  logic                 owner_req_s;
  logic                 found_s;
  logic [SEL_W-1:0]     pick_s;
  logic [SEL_W-1:0]     cand_s;
  logic                 job_s;
  logic                 abort_s;
  logic [2:0]           cmd_s;
  logic [1:0]           opnd_s;
  logic                 valid_s;
  logic                 busy_s;

  // Round-robin successor of an owner index, wrapping at NUM_REQ.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    if (idx == SEL_W'(NUM_REQ - 1)) begin
      return SEL_W'(0);
    end else begin
      return idx + SEL_W'(1);
    end
  endfunction

  assign req_ext_s   = NSEL'(req);
  assign owner_req_s = req_ext_s[sel_r];

  // Arbiter: first requesting index at or after ptr, modulo NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = SEL_W'(0);
    cand_s  = SEL_W'(0);
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = SEL_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!found_s && req_ext_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Output decode from state; an owner dropping req suppresses the op that cycle.
  always_comb begin
    cmd_s   = CMD_HOLD;
    opnd_s  = 2'd0;
    valid_s = 1'b0;
    busy_s  = 1'b1;
    job_s   = 1'b0;
    case (state_r)
      S_CAP:  begin cmd_s = CMD_CAPTURE; opnd_s = 2'd0; job_s = 1'b1; end
      S_ADD:  begin cmd_s = CMD_ADD;     opnd_s = 2'd1; job_s = 1'b1; end
      S_SUB1: begin cmd_s = CMD_SUB;     opnd_s = 2'd2; job_s = 1'b1; end
      S_SUB2: begin cmd_s = CMD_SUB;     opnd_s = 2'd3; job_s = 1'b1; end
      S_DONE: valid_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
    abort_s = job_s && !owner_req_s;
    if (abort_s) begin
      cmd_s = CMD_HOLD;
    end else begin
      cmd_s = cmd_s;
    end
  end

  // Job sequencer with registered grant, owner, result id and priority pointer.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      gnt_r     <= NUM_REQ'(0);
      sel_r     <= SEL_W'(0);
      done_id_r <= SEL_W'(0);
      ptr_r     <= SEL_W'(0);
    end else if (abort_s) begin
      state_r <= S_IDLE;
      gnt_r   <= NUM_REQ'(0);
      ptr_r   <= next_idx(sel_r);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            state_r <= S_CAP;
            gnt_r   <= NUM_REQ'(1) << pick_s;
            sel_r   <= pick_s;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CAP:  state_r <= S_ADD;
        S_ADD:  state_r <= S_SUB1;
        S_SUB1: state_r <= S_SUB2;
        S_SUB2: begin
          state_r   <= S_DONE;
          done_id_r <= sel_r;
        end
        S_DONE: begin
          state_r <= S_IDLE;
          gnt_r   <= NUM_REQ'(0);
          ptr_r   <= next_idx(sel_r);
        end
        default: begin
          state_r <= S_IDLE;
          gnt_r   <= NUM_REQ'(0);
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign done_id = done_id_r;
  assign opnd    = opnd_s;
  assign cmd     = cmd_s;
  assign valid   = valid_s;
  assign abort   = abort_s;
  assign busy    = busy_s;
  assign ack     = valid_s ? (NUM_REQ'(1) << sel_r) : NUM_REQ'(0);

endmodule

// File: tb/tb_accum_scheduler.sv
// Randomized scoreboard bench for accum_scheduler: a job-level reference model
// predicts every cycle's outputs and each job's accumulated result.
module tb_accum_scheduler;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [1:0]   sel;
  logic [1:0]   opnd;
  logic [2:0]   cmd;
  logic         valid;
  logic [1:0]   done_id;
  logic [N-1:0] ack;
  logic         abort;
  logic         busy;

  always #5 clock = ~clock;

  accum_scheduler #(.NUM_REQ(N), .SEL_W(2)) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel),
    .opnd(opnd), .cmd(cmd), .valid(valid), .done_id(done_id), .ack(ack),
    .abort(abort), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [2:0]   cmd;
    logic [1:0]   opnd;
    logic         busy;
    logic         valid;
    logic         abort;
    logic [N-1:0] ack;
    logic         sel_chk;
    logic [1:0]   sel;
    logic         did_chk;
    logic [1:0]   did;
  } cyc_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
  } evt_t;

  cyc_t cyc_q[$];
  evt_t evt_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0]  opnds [N][4];
  logic [15:0]  acc;
  logic [N-1:0] want;

  // reference model: job in progress, its phase (0..3 ops, 4 = result), owner, priority pointer
  bit m_busy;
  int m_phase;
  int m_owner;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_operands(input int o);
    for (int j = 0; j < 4; j++) opnds[o][j] = 16'($urandom);
  endtask

  task automatic model_step(input logic [N-1:0] r, output cyc_t e);
    evt_t v;
    bit   found;
    int   k;
    e = '0;
    if (!m_busy) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && r[k]) begin
          found   = 1'b1;
          m_owner = k;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_phase = 0;
      end
    end else begin
      e.gnt     = N'(1) << m_owner;
      e.busy    = 1'b1;
      e.sel_chk = 1'b1;
      e.sel     = 2'(m_owner);
      if (m_phase < 4) begin
        e.opnd = 2'(m_phase);
        if (r[m_owner]) begin
          e.cmd   = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
          m_phase = m_phase + 1;
        end else begin
          e.abort = 1'b1;
          m_busy  = 1'b0;
          m_ptr   = (m_owner + 1) % N;
        end
      end else begin
        e.valid   = 1'b1;
        e.ack     = N'(1) << m_owner;
        e.did_chk = 1'b1;
        e.did     = 2'(m_owner);
        v.id      = 2'(m_owner);
        v.res     = opnds[m_owner][0] + opnds[m_owner][1] - opnds[m_owner][2] - opnds[m_owner][3];
        evt_q.push_back(v);
        m_busy    = 1'b0;
        m_ptr     = (m_owner + 1) % N;
      end
    end
  endtask

  // stand-in for the shared accumulator datapath, fed from the owner's operands
  always @(posedge clock) begin
    case (cmd)
      3'b001:  acc <= opnds[sel][opnd];
      3'b010:  acc <= acc + opnds[sel][opnd];
      3'b100:  acc <= acc - opnds[sel][opnd];
      default: acc <= acc;
    endcase
  end

  initial begin : monitor
    cyc_t e;
    evt_t v;
    forever begin
      @(negedge clock);
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("gnt",   32'(gnt),   32'(e.gnt));
        check("cmd",   32'(cmd),   32'(e.cmd));
        check("opnd",  32'(opnd),  32'(e.opnd));
        check("busy",  32'(busy),  32'(e.busy));
        check("valid", 32'(valid), 32'(e.valid));
        check("abort", 32'(abort), 32'(e.abort));
        check("ack",   32'(ack),   32'(e.ack));
        if (e.sel_chk) check("sel", 32'(sel), 32'(e.sel));
        if (e.did_chk) check("done_id", 32'(done_id), 32'(e.did));
        if (e.valid) begin
          if (evt_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL evt_q: expected job result missing from scoreboard at %0t", $time);
          end else begin
            v = evt_q.pop_front();
            check("result_id", 32'(done_id), 32'(v.id));
            check("result",    32'(acc),     32'(v.res));
          end
        end
      end
    end
  end

  initial begin : driver
    cyc_t e;
    int   o;
    bit   rl;
    want    = '0;
    m_busy  = 1'b0;
    m_phase = 0;
    m_owner = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) new_operands(i);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock);
      #1;
      rl = (cyc < 3) || (m_busy && m_phase == 2 && $urandom_range(0, 30) == 0);
      if (rl) begin
        rst_n  = 1'b0;
        e      = '0;
        e.sel_chk = 1'b1;
        e.did_chk = 1'b1;
        m_busy = 1'b0;
        m_ptr  = 0;
        cyc_q.push_back(e);
      end else begin
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (m_busy && i == m_owner && m_phase < 4 && $urandom_range(0, 15) == 0)
            want[i] = 1'b0;
          else if (!want[i] && $urandom_range(0, 2) == 0)
            want[i] = 1'b1;
        end
        req = want;
        o   = m_owner;
        model_step(want, e);
        cyc_q.push_back(e);
        if (e.valid) begin
          want[o] = 1'($urandom_range(0, 1));
          new_operands(o);
        end
        if (e.abort) new_operands(o);
      end
    end
    @(negedge clock);
    #1;
    check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    check("evt_q_drained", 32'(evt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
